// File: rtl/aib_axi_tx_sched.sv
// -----------------------------------------------------------------------------
// aib_axi_tx_sched
//
// Credit-based transmit scheduler for the master side of the AXI-over-AIB
// bridge. The AW, W and AR request channels are arbitrated round-robin
// (order AW -> W -> AR) onto the single AIB transmit slot. Only channels
// holding far-end credit may be granted, and a W burst keeps the slot until
// its last beat is sent. Everything is on the rising edge of clk_wr.
//
// Handshake: a flit moves on a channel in exactly the cycle where that
// channel's grant is high. A grant can only be high when the channel's req is
// high, tx_ready is high, the channel has credit and the link is running, so
// grant itself is the transfer strobe for both the packer and the framer.
//
// Ports
//   clk_wr, rst_wr             clock, synchronous active-high reset
//   i_conf_done                AIB link configured (level)
//   init_{aw,w,ar}_credit      initial credits, taken during LOAD
//   {aw,w,ar}_req              channel has a flit ready
//   w_last                     current W flit ends its burst
//   tx_ready                   framer accepts a flit this cycle
//   {aw,w,ar}_cred_ret         +1 credit return pulse from the far end
//   {aw,w,ar}_gnt              combinational one-hot grant
//   tx_sel                     00=AW 01=W 10=AR 11=none (combinational)
//   {aw,w,ar}_credit           registered credit counters
//   link_active                registered, high while in RUN
//   credit_err                 registered sticky credit-overflow flag
//   o_dbg_state                FSM state: 0=IDLE 1=LOAD 2=RUN
// -----------------------------------------------------------------------------
module aib_axi_tx_sched #(
    parameter int CREDIT_W = 8
) (
    input  logic                clk_wr,
    input  logic                rst_wr,
    input  logic                i_conf_done,
    input  logic [CREDIT_W-1:0] init_aw_credit,
    input  logic [CREDIT_W-1:0] init_w_credit,
    input  logic [CREDIT_W-1:0] init_ar_credit,
    input  logic                aw_req,
    input  logic                w_req,
    input  logic                ar_req,
    input  logic                w_last,
    input  logic                tx_ready,
    input  logic                aw_cred_ret,
    input  logic                w_cred_ret,
    input  logic                ar_cred_ret,
    output logic                aw_gnt,
    output logic                w_gnt,
    output logic                ar_gnt,
    output logic [1:0]          tx_sel,
    output logic [CREDIT_W-1:0] aw_credit,
    output logic [CREDIT_W-1:0] w_credit,
    output logic [CREDIT_W-1:0] ar_credit,
    output logic                link_active,
    output logic                credit_err,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Round-robin pointer encoding: the channel that has first priority.
    localparam logic [1:0] PTR_AW = 2'd0;
    localparam logic [1:0] PTR_W  = 2'd1;
    localparam logic [1:0] PTR_AR = 2'd2;

    localparam logic [CREDIT_W-1:0] CRED_ONE  = {{(CREDIT_W-1){1'b0}}, 1'b1};
    localparam logic [CREDIT_W-1:0] CRED_ZERO = '0;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_ptr;
    logic                r_w_lock;
    logic [CREDIT_W-1:0] r_aw_credit;
    logic [CREDIT_W-1:0] r_w_credit;
    logic [CREDIT_W-1:0] r_ar_credit;
    logic                r_link_active;
    logic                r_credit_err;

    logic                w_run_active;
    logic                w_sched_en;
    logic                w_elig_aw;
    logic                w_elig_w;
    logic                w_elig_ar;
    logic                w_gnt_aw;
    logic                w_gnt_w;
    logic                w_gnt_ar;
    logic [1:0]          w_ptr_next;
    logic [CREDIT_W-1:0] w_aw_credit_next;
    logic [CREDIT_W-1:0] w_w_credit_next;
    logic [CREDIT_W-1:0] w_ar_credit_next;
    logic                w_ovf_aw;
    logic                w_ovf_w;
    logic                w_ovf_ar;

    // -------------------------------------------------------------------------
    // FSM: state register and next-state logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_conf_done) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_RUN;
            ST_RUN:  if (!i_conf_done) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // RUN with the link still configured; the cycle in which i_conf_done
    // drops is already treated as "not running" so grants stop immediately.
    assign w_run_active = (r_state == ST_RUN) && i_conf_done;

    // Reset is folded in so a reset cycle never launches a flit that the
    // counters would then fail to account for.
    assign w_sched_en = w_run_active && tx_ready && !rst_wr;

    assign w_elig_aw = w_sched_en && aw_req && (r_aw_credit != CRED_ZERO);
    assign w_elig_w  = w_sched_en && w_req  && (r_w_credit  != CRED_ZERO);
    assign w_elig_ar = w_sched_en && ar_req && (r_ar_credit != CRED_ZERO);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    always_comb begin
        w_gnt_aw = 1'b0;
        w_gnt_w  = 1'b0;
        w_gnt_ar = 1'b0;
        if (r_w_lock) begin
            // Mid-burst: only W may go, and if it has no credit nobody goes.
            w_gnt_w = w_elig_w;
        end else begin
            case (r_ptr)
                PTR_W: begin
                    if (w_elig_w)        w_gnt_w  = 1'b1;
                    else if (w_elig_ar)  w_gnt_ar = 1'b1;
                    else if (w_elig_aw)  w_gnt_aw = 1'b1;
                end
                PTR_AR: begin
                    if (w_elig_ar)       w_gnt_ar = 1'b1;
                    else if (w_elig_aw)  w_gnt_aw = 1'b1;
                    else if (w_elig_w)   w_gnt_w  = 1'b1;
                end
                default: begin
                    if (w_elig_aw)       w_gnt_aw = 1'b1;
                    else if (w_elig_w)   w_gnt_w  = 1'b1;
                    else if (w_elig_ar)  w_gnt_ar = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        tx_sel = 2'b11;
        if (w_gnt_aw)      tx_sel = 2'b00;
        else if (w_gnt_w)  tx_sel = 2'b01;
        else if (w_gnt_ar) tx_sel = 2'b10;
    end

    // Pointer moves to the channel after the one granted; holds otherwise.
    always_comb begin
        w_ptr_next = r_ptr;
        if (w_gnt_aw)      w_ptr_next = PTR_W;
        else if (w_gnt_w)  w_ptr_next = PTR_AR;
        else if (w_gnt_ar) w_ptr_next = PTR_AW;
    end

    // -------------------------------------------------------------------------
    // Credit arithmetic. Grant and return in the same cycle cancel out.
    // A return into an all-ones counter is dropped and flagged.
    // -------------------------------------------------------------------------
    always_comb begin
        w_aw_credit_next = r_aw_credit;
        w_ovf_aw         = 1'b0;
        if (w_gnt_aw && !aw_cred_ret) begin
            w_aw_credit_next = r_aw_credit - CRED_ONE;
        end else if (aw_cred_ret && !w_gnt_aw) begin
            if (&r_aw_credit) w_ovf_aw = 1'b1;
            else              w_aw_credit_next = r_aw_credit + CRED_ONE;
        end
    end

    always_comb begin
        w_w_credit_next = r_w_credit;
        w_ovf_w         = 1'b0;
        if (w_gnt_w && !w_cred_ret) begin
            w_w_credit_next = r_w_credit - CRED_ONE;
        end else if (w_cred_ret && !w_gnt_w) begin
            if (&r_w_credit) w_ovf_w = 1'b1;
            else             w_w_credit_next = r_w_credit + CRED_ONE;
        end
    end

    always_comb begin
        w_ar_credit_next = r_ar_credit;
        w_ovf_ar         = 1'b0;
        if (w_gnt_ar && !ar_cred_ret) begin
            w_ar_credit_next = r_ar_credit - CRED_ONE;
        end else if (ar_cred_ret && !w_gnt_ar) begin
            if (&r_ar_credit) w_ovf_ar = 1'b1;
            else              w_ar_credit_next = r_ar_credit + CRED_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            r_aw_credit   <= CRED_ZERO;
            r_w_credit    <= CRED_ZERO;
            r_ar_credit   <= CRED_ZERO;
            r_ptr         <= PTR_AW;
            r_w_lock      <= 1'b0;
            r_link_active <= 1'b0;
            r_credit_err  <= 1'b0;
        end else begin
            r_link_active <= (w_next_state == ST_RUN);
            case (r_state)
                ST_LOAD: begin
                    // Returns arriving now are ignored; the init value wins.
                    r_aw_credit <= init_aw_credit;
                    r_w_credit  <= init_w_credit;
                    r_ar_credit <= init_ar_credit;
                end
                ST_RUN: begin
                    if (i_conf_done) begin
                        r_aw_credit <= w_aw_credit_next;
                        r_w_credit  <= w_w_credit_next;
                        r_ar_credit <= w_ar_credit_next;
                        r_ptr       <= w_ptr_next;
                        if (w_gnt_w) r_w_lock <= !w_last;
                        if (w_ovf_aw || w_ovf_w || w_ovf_ar) r_credit_err <= 1'b1;
                    end else begin
                        // Link dropped: abandon everything but the error flag.
                        r_aw_credit <= CRED_ZERO;
                        r_w_credit  <= CRED_ZERO;
                        r_ar_credit <= CRED_ZERO;
                        r_ptr       <= PTR_AW;
                        r_w_lock    <= 1'b0;
                    end
                end
                default: begin
                    r_aw_credit <= CRED_ZERO;
                    r_w_credit  <= CRED_ZERO;
                    r_ar_credit <= CRED_ZERO;
                    r_ptr       <= PTR_AW;
                    r_w_lock    <= 1'b0;
                end
            endcase
        end
    end

    assign aw_gnt      = w_gnt_aw;
    assign w_gnt       = w_gnt_w;
    assign ar_gnt      = w_gnt_ar;
    assign aw_credit   = r_aw_credit;
    assign w_credit    = r_w_credit;
    assign ar_credit   = r_ar_credit;
    assign link_active = r_link_active;
    assign credit_err  = r_credit_err;
    assign o_dbg_state = r_state;

endmodule
